// File: rtl/hs_stream_gen.sv
// hs_stream_gen: burst stream generator with a valid/ready source port.
// A transfer of num_bursts bursts of BURST_LEN beats is launched by start;
// payload follows a pattern picked by mode (increment, stride, LFSR, hold).
// Optional feature macro: HS_STREAM_GEN_LFSR_EN enables the Galois LFSR
// pattern for mode 2'b10; without it mode 2'b10 behaves as mode 2'b00.
module hs_stream_gen #(
  parameter int               WIDTH     = 8,
  parameter int               BURST_LEN = 4,
  parameter int               CNT_W     = 16,
  parameter logic [WIDTH-1:0] POLY      = WIDTH'(8'hB8)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             en,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_bursts,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] stride,
  input  logic [WIDTH-1:0] seed,
  input  logic             m_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             busy,
  output logic             done
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] BEAT_MAX = BW'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [BW-1:0]    beat_cnt;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] cfg_num;
  logic [1:0]       cfg_mode;
  logic [WIDTH-1:0] cfg_stride;
  logic             abort_pend;
  logic             beat_wrap;
  logic             xfer_end;

`ifndef HS_STREAM_GEN_LFSR_EN
  // POLY only feeds the LFSR; keep it referenced in the plain build.
  logic unused_poly;
  assign unused_poly = ^POLY;
`endif

  // First payload value of a transfer; an all-zero LFSR state would lock up.
  function automatic logic [WIDTH-1:0] load_value(input logic [1:0] md,
                                                  input logic [WIDTH-1:0] sd);
`ifdef HS_STREAM_GEN_LFSR_EN
    if (md == 2'b10 && sd == '0) return WIDTH'(1);
    return sd;
`else
    if (md == 2'b11) return sd;
    return sd;
`endif
  endfunction

  // Payload following cur for the configured pattern, modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] next_data(input logic [1:0] md,
                                                 input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] stp);
    case (md)
      2'b00:   return cur + WIDTH'(1);
      2'b01:   return cur + stp;
`ifdef HS_STREAM_GEN_LFSR_EN
      2'b10:   return cur[0] ? ((cur >> 1) ^ POLY) : (cur >> 1);
`else
      2'b10:   return cur + WIDTH'(1);
`endif
      default: return cur;
    endcase
  endfunction

  assign beat_wrap = (beat_cnt == BEAT_MAX);
  assign xfer_end  = beat_wrap && (burst_cnt == cfg_num - CNT_W'(1));

  assign m_last = m_valid && beat_wrap;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  // Transfer sequencing, beat/burst counting and the registered source port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      m_valid    <= 1'b0;
      m_data     <= '0;
      beat_cnt   <= '0;
      burst_cnt  <= '0;
      cfg_num    <= '0;
      cfg_mode   <= 2'b00;
      cfg_stride <= '0;
      abort_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (num_bursts != '0) begin
              cfg_num    <= num_bursts;
              cfg_mode   <= mode;
              cfg_stride <= stride;
              m_data     <= load_value(mode, seed);
              beat_cnt   <= '0;
              burst_cnt  <= '0;
              abort_pend <= 1'b0;
              m_valid    <= en;
              state      <= RUN;
            end else begin
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (m_valid) begin
            if (m_ready) begin
              // An abort seen with or before this handshake ends the transfer here.
              if (xfer_end || abort_pend || abort) begin
                m_valid    <= 1'b0;
                abort_pend <= 1'b0;
                state      <= DONE;
              end else begin
                m_data  <= next_data(cfg_mode, m_data, cfg_stride);
                m_valid <= en;
                if (beat_wrap) begin
                  beat_cnt  <= '0;
                  burst_cnt <= burst_cnt + CNT_W'(1);
                end else begin
                  beat_cnt <= beat_cnt + BW'(1);
                end
              end
            end else if (abort) begin
              abort_pend <= 1'b1;
            end
          end else if (abort) begin
            state <= DONE;
          end else if (en) begin
            m_valid <= 1'b1;
          end
        end
        DONE: begin
          abort_pend <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hs_stream_gen.sv
// Bench for hs_stream_gen: directed table, hand-written corner sequences and
// randomized transfers checked against a beat-list reference model.
module tb_hs_stream_gen;
  localparam int W  = 8;
  localparam int BL = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n, start, en, abort, m_ready;
  logic [CW-1:0] num_bursts;
  logic [1:0]    mode;
  logic [W-1:0]  stride, seed;
  logic          m_valid, m_last, busy, done;
  logic [W-1:0]  m_data;

  always #5 clk = ~clk;

  hs_stream_gen #(.WIDTH(W), .BURST_LEN(BL), .CNT_W(CW), .POLY(8'hB8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .en(en), .abort(abort),
    .num_bursts(num_bursts), .mode(mode), .stride(stride), .seed(seed),
    .m_ready(m_ready), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  int errs = 0;
  int checks = 0;

  logic [7:0] cap_d[$];
  logic       cap_l[$];
  int         cap_cyc[$];
  int         done_cyc;

  typedef struct {
    logic [1:0]  md;
    logic [7:0]  sd;
    logic [7:0]  st;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: value of beat idx of a transfer, straight from the pattern rules.
  function automatic logic [7:0] model_data(input logic [1:0] md, input logic [7:0] sd,
                                            input logic [7:0] st, input int idx);
    logic [7:0] v;
    case (md)
      2'd0: return sd + 8'(idx);
      2'd1: return sd + 8'(idx) * st;
      2'd3: return sd;
      default: begin
`ifdef HS_STREAM_GEN_LFSR_EN
        v = (sd == 8'd0) ? 8'd1 : sd;
        for (int k = 0; k < idx; k++) v = v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
        return v;
`else
        v = sd + 8'(idx);
        return v;
`endif
      end
    endcase
  endfunction

  // en_mode: 0 always 1, 1 toggle, 2 random, 3 always 0.
  // rdy_mode: 0 always 1, 1 random.
  task automatic run_xfer(input logic [1:0] md, input logic [7:0] sd, input logic [7:0] st,
                          input logic [CW-1:0] nb, input int en_mode, input int rdy_mode,
                          input int stall_beat, input int stall_len, input bit abort_on_stall,
                          input int abort_cyc, input bit restart);
    int   cyc, stall_cnt;
    bit   stalled, got_done, hs, phs, first;
    logic pv, pr, pl, en0;
    logic [7:0] pd;
    cap_d.delete(); cap_l.delete(); cap_cyc.delete();
    done_cyc = -1; stall_cnt = 0; got_done = 0; first = 1;
    phs = 0; pv = 0; pr = 0; pl = 0; pd = '0;
    en0 = (en_mode == 3) ? 1'b0 : (en_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start = 1'b1; mode = md; seed = sd; stride = st; num_bursts = nb;
    en = en0; m_ready = 1'b0; abort = 1'b0;
    for (cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk); #1;
      start = restart && (cyc == 2);
      if (restart) begin seed = ~sd; mode = 2'd1; stride = 8'h33; end
      case (en_mode)
        0: en = 1'b1;
        1: en = 1'(cyc % 2);
        2: en = 1'($urandom_range(0, 1));
        default: en = 1'b0;
      endcase
      stalled = (cap_d.size() == stall_beat) && (stall_cnt < stall_len);
      if (stalled) begin
        m_ready = 1'b0;
        stall_cnt++;
      end else begin
        m_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
      abort = (abort_on_stall && stalled && stall_cnt == 1) || (cyc == abort_cyc);
      @(negedge clk);
      hs = m_valid && m_ready;
      if (first) begin
        if (nb != '0) chk("first_valid_eq_en", 64'(m_valid), 64'(en0));
        first = 0;
      end else begin
        if (!phs) chk("data_stable_no_hs", 64'(m_data), 64'(pd));
        if (pv && !pr) begin
          chk("valid_held", 64'(m_valid), 64'(1));
          chk("last_held", 64'(m_last), 64'(pl));
        end
      end
      if (hs) begin
        cap_d.push_back(m_data);
        cap_l.push_back(m_last);
        cap_cyc.push_back(cyc);
      end
      if (done) begin
        done_cyc = cyc;
        got_done = 1;
        chk("busy_at_done", 64'(busy), 64'(1));
        chk("valid_at_done", 64'(m_valid), 64'(0));
        break;
      end
      phs = hs; pv = m_valid; pr = m_ready; pl = m_last; pd = m_data;
    end
    if (!got_done) begin
      checks++; errs++;
      $display("FAIL xfer_timeout: no done within 2000 cycles");
    end else begin
      @(posedge clk); #1;
      start = 1'b0; en = 1'b0; m_ready = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'(0));
      chk("busy_falls", 64'(busy), 64'(0));
    end
  endtask

  task automatic check_beats(input logic [1:0] md, input logic [7:0] sd, input logic [7:0] st,
                             input int n);
    chk("beat_count", 64'(cap_d.size()), 64'(n));
    for (int i = 0; i < n && i < cap_d.size(); i++) begin
      chk("beat_data", 64'(cap_d[i]), 64'(model_data(md, sd, st, i)));
      chk("beat_last", 64'(cap_l[i]), 64'((i % BL) == BL - 1));
    end
  endtask

  task automatic check_req039();
    check_beats(2'd0, 8'hFE, 8'h00, 8);
    if (cap_cyc.size() == 8) begin
      chk("back_to_back", 64'(cap_cyc[7] - cap_cyc[0]), 64'(7));
      chk("done_after_last", 64'(done_cyc), 64'(cap_cyc[7] + 1));
    end
  endtask

  initial begin
    logic [7:0] md_r, sd_r, st_r;
    logic [CW-1:0] nb_r;
    logic [7:0] e;

    tbl[0] = '{2'd0, 8'hFE, 8'h00, 32'hFEFF0001};
    tbl[1] = '{2'd1, 8'hF0, 8'h10, 32'hF0001020};
    tbl[2] = '{2'd3, 8'h5A, 8'h77, 32'h5A5A5A5A};
`ifdef HS_STREAM_GEN_LFSR_EN
    tbl[3] = '{2'd2, 8'h00, 8'h00, 32'h01B85C2E};
`else
    tbl[3] = '{2'd2, 8'h00, 8'h00, 32'h00010203};
`endif
    tbl[4] = '{2'd0, 8'h7F, 8'h55, 32'h7F808182};
    tbl[5] = '{2'd1, 8'h03, 8'hFF, 32'h03020100};

    rst_n = 1'b0; start = 1'b0; en = 1'b0; abort = 1'b0; m_ready = 1'b0;
    num_bursts = '0; mode = 2'd0; stride = '0; seed = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(m_valid), 64'(0));
    chk("rst_data", 64'(m_data), 64'(0));
    chk("rst_last", 64'(m_last), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    @(posedge clk); #1; rst_n = 1'b1;

    // Directed table, one burst each, full throughput.
    for (int v = 0; v < 6; v++) begin
      run_xfer(tbl[v].md, tbl[v].sd, tbl[v].st, 4'd1, 0, 0, -1, 0, 0, -1, 0);
      chk("tbl_count", 64'(cap_d.size()), 64'(4));
      for (int i = 0; i < 4 && i < cap_d.size(); i++) begin
        e = tbl[v].exp[31 - 8*i -: 8];
        chk("tbl_data", 64'(cap_d[i]), 64'(e));
      end
    end

    // Two bursts from FE, wrapping through zero.
    run_xfer(2'd0, 8'hFE, 8'h00, 4'd2, 0, 0, -1, 0, 0, -1, 0);
    check_req039();

    // Second beat stalled for three cycles.
    run_xfer(2'd0, 8'hFE, 8'h00, 4'd2, 0, 0, 1, 3, 0, -1, 0);
    check_beats(2'd0, 8'hFE, 8'h00, 8);
    if (cap_cyc.size() >= 2) chk("stall_gap", 64'(cap_cyc[1] - cap_cyc[0]), 64'(4));

    // en toggling every cycle: beats spaced by gaps, never withdrawn.
    run_xfer(2'd1, 8'hF0, 8'h10, 4'd1, 1, 0, -1, 0, 0, -1, 0);
    check_beats(2'd1, 8'hF0, 8'h10, 4);
    for (int i = 0; i < 4 && i < cap_cyc.size(); i++)
      chk("toggle_spacing", 64'(cap_cyc[i]), 64'(2 * i));

    // Abort while beat 3 is stalled: beat 3 completes, nothing after.
    run_xfer(2'd0, 8'hFE, 8'h00, 4'd2, 0, 0, 2, 3, 1, -1, 0);
    check_beats(2'd0, 8'hFE, 8'h00, 3);

    // Abort with nothing pending.
    run_xfer(2'd0, 8'h11, 8'h00, 4'd2, 3, 0, -1, 0, 0, 1, 0);
    check_beats(2'd0, 8'h11, 8'h00, 0);
    chk("abort_idle_done", 64'(done_cyc), 64'(2));

    // Zero bursts: straight to DONE.
    run_xfer(2'd0, 8'h22, 8'h00, 4'd0, 0, 0, -1, 0, 0, -1, 0);
    check_beats(2'd0, 8'h22, 8'h00, 0);
    chk("zero_burst_done", 64'(done_cyc), 64'(0));

    // start during RUN is ignored.
    run_xfer(2'd0, 8'h10, 8'h00, 4'd1, 0, 0, -1, 0, 0, -1, 1);
    check_beats(2'd0, 8'h10, 8'h00, 4);

    // Largest burst count with random throttle and backpressure.
    run_xfer(2'd1, 8'h09, 8'h05, 4'd15, 2, 1, -1, 0, 0, -1, 0);
    check_beats(2'd1, 8'h09, 8'h05, 15 * BL);

    // Reset during beat 2, then a fresh transfer.
    @(posedge clk); #1;
    start = 1'b1; mode = 2'd0; seed = 8'hFE; num_bursts = 4'd2; en = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_data", 64'(m_data), 64'(8'hFF));
    #2; rst_n = 1'b0; #1;
    chk("async_rst_valid", 64'(m_valid), 64'(0));
    chk("async_rst_data", 64'(m_data), 64'(0));
    chk("async_rst_last", 64'(m_last), 64'(0));
    chk("async_rst_busy", 64'(busy), 64'(0));
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_done", 64'(done), 64'(0));
    end
    @(posedge clk); #1; rst_n = 1'b1; en = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    chk("post_rst_no_done", 64'(done), 64'(0));
    run_xfer(2'd0, 8'hFE, 8'h00, 4'd2, 0, 0, -1, 0, 0, -1, 0);
    check_req039();

    // Randomized transfers against the model.
    for (int t = 0; t < 15; t++) begin
      md_r = 8'($urandom_range(0, 3));
      sd_r = 8'($urandom);
      st_r = 8'($urandom);
      nb_r = CW'($urandom_range(1, 3));
      run_xfer(md_r[1:0], sd_r, st_r, nb_r, 2, 1, -1, 0, 0, -1, 0);
      check_beats(md_r[1:0], sd_r, st_r, int'(nb_r) * BL);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/hs_stream_gen.md
HS_STREAM_GEN -- requirements
Module: hs_stream_gen

Interface
- REQ-001: Parameter WIDTH, default 8: data width in bits, range 2..64.
- REQ-002: Parameter BURST_LEN, default 4: beats per burst, range 1..256.
- REQ-003: Parameter CNT_W, default 16: width of num_bursts.
- REQ-004: Parameter POLY, default 8'hB8: Galois LFSR feedback mask, WIDTH bits.
- REQ-005: clk  in  1  clock; all state SHALL update on its rising edge.
- REQ-006: rst_n  in  1  reset, asynchronous, active-low.
- REQ-007: start  in  1  single-cycle request to begin a transfer.
- REQ-008: en  in  1  throttle; 0 blocks new beats.
- REQ-009: abort  in  1  request to end the transfer early.
- REQ-010: num_bursts  in  CNT_W  bursts per transfer, sampled at start.
- REQ-011: mode  in  2  data pattern, sampled at start.
- REQ-012: stride  in  WIDTH  increment for mode 01, sampled at start.
- REQ-013: seed  in  WIDTH  first data value, sampled at start.
- REQ-014: m_ready  in  1  sink ready.
- REQ-015: m_valid  out  1  beat valid, registered.
- REQ-016: m_data  out  WIDTH  beat payload, registered.
- REQ-017: m_last  out  1  high on the final beat of each burst.
- REQ-018: busy  out  1  high when state is not IDLE.
- REQ-019: done  out  1  one-cycle pulse marking the end of a transfer.

Function
- REQ-020: The FSM SHALL have three states: IDLE, RUN and DONE. DONE SHALL last exactly one cycle with done=1, then return to IDLE.
- REQ-021: In IDLE, start=1 with num_bursts!=0 SHALL load the configuration, set m_data=seed and clear the beat and burst counters, then enter RUN.
  - On that same edge, m_valid SHALL be set equal to en.
- REQ-022: In IDLE, start=1 with num_bursts=0 SHALL enter DONE directly, with no beats issued.
- REQ-023: start SHALL be ignored when state is RUN or DONE.
- REQ-024: Handshake rule: once m_valid=1, m_valid, m_data and m_last SHALL hold stable until m_valid&m_ready. en, abort and stride SHALL NOT affect a pending beat.
- REQ-025: In RUN with m_valid=0, m_valid SHALL rise on the next edge when en=1.
- REQ-026: On a handshake that is not the final beat:
  - m_data SHALL advance;
  - the beat counter SHALL increment, wrapping to 0 after BURST_LEN-1, with the burst counter incrementing on that wrap;
  - the next m_valid SHALL equal en sampled on the same edge, giving back-to-back throughput of 1 beat/cycle.
- REQ-027: m_last SHALL equal m_valid AND (beat counter == BURST_LEN-1). With BURST_LEN=1, every beat SHALL be last.
- REQ-028: A handshake on the last beat of burst num_bursts-1 SHALL drop m_valid and enter DONE.
- REQ-029: abort in RUN with m_valid=0 SHALL enter DONE on the next edge.
- REQ-030: abort in RUN with m_valid=1 SHALL be latched. After the pending beat handshakes, the block SHALL enter DONE with no further beats issued.
- REQ-031: Data patterns, with all arithmetic modulo 2^WIDTH:
  - mode 00: m_data+1;
  - mode 01: m_data+stride;
  - mode 10: Galois LFSR step, where the value is shifted right and XORed with POLY if the shifted-out bit was 1;
  - mode 11: hold seed.
- REQ-032: In mode 10, seed=0 SHALL be replaced by 1 at load.
- REQ-033: m_data SHALL NOT change on cycles without a handshake, including while en=0.
- REQ-034: The burst counter SHALL be CNT_W bits wide. num_bursts=2^CNT_W-1 SHALL complete without overflow.

Reset
- REQ-035: Reset SHALL force state=IDLE, m_valid=0, m_data=0, m_last=0, busy=0, done=0, with all counters and latched configuration cleared.
- REQ-036: Reset asserted mid-transfer SHALL drop m_valid immediately (asynchronously) with no done pulse. The first transfer after release SHALL behave as from power-up.

Configuration
- REQ-037: Macro HS_STREAM_GEN_LFSR_EN defined: mode 10 SHALL behave per REQ-031 and REQ-032.
- REQ-038: Macro HS_STREAM_GEN_LFSR_EN undefined: no LFSR logic SHALL be synthesised, and mode 10 SHALL behave as mode 00.

Verification
- REQ-039: WIDTH=8, BURST_LEN=4, mode 00, seed 8'hFE, num_bursts=2, en=1, m_ready=1 -> data FE,FF,00,01,02,03,04,05 on consecutive cycles; m_last on beats 4 and 8; done pulses 1 cycle after beat 8.
- REQ-040: Same setup, m_ready low for 3 cycles on beat 2 -> m_valid=1 and m_data=FF held all 3 cycles; total beats still 8.
- REQ-041: mode 01, stride 8'h10, seed 8'hF0, en toggled 1,0,1,0 every cycle with m_ready=1 -> data F0,00,10,20 with valid gaps; a pending beat is never withdrawn when en falls.
- REQ-042: abort asserted while beat 3 is stalled -> beat 3 completes on m_ready; no beat 4; done pulses; busy falls the next cycle.
- REQ-043: With the macro defined, mode 10, seed 0, POLY 8'hB8 -> beats 01,B8,5C,2E. With the macro undefined, the same stimulus -> 00,01,02,03.
- REQ-044: rst_n pulsed low during beat 2 of 8 -> outputs zero immediately; no done pulse; a fresh start then reproduces the REQ-039 sequence.
